lsu_dbus_ctrl: RTL and testbench
================================

// Module: lsu_dbus_ctrl
// PURPOSE
//  MEM-stage load/store unit data-bus controller. Drives a 32-bit memory-mapped
//  master (waitrequest/readdatavalid handshake). Formats store data and byte enables,
//  aligns and sign-extends load data. Generates lsu_dbus_busy, which feeds the hazard
//  detection unit to stall the pipeline. Registered load data is consumed by WB.
// PARAMETERS
//  AW  32  data bus address width
//  DW  32  data bus width; fixed at 32 and not legal to change
// PORTS
//  clk                 in   1   core clock
//  rst_b               in   1   asynchronous active-low reset
//  mem_mem_read        in   1   MEM-stage instruction is a load
//  mem_mem_write       in   1   MEM-stage instruction is a store
//  mem_funct3          in   3   LB=000 LH=001 LW=010 LBU=100 LHU=101; SB/SH/SW=000/001/010
//  mem_address         in   AW  effective address
//  mem_wdata           in   32  store source (rs2)
//  trap_take           in   1   trap taken in WB; kills the MEM access
//  dbus_read           out  1   bus read request
//  dbus_write          out  1   bus write request
//  dbus_address        out  AW  word-aligned address ({mem_address[AW-1:2],2'b0})
//  dbus_writedata      out  32  lane-replicated store data
//  dbus_byteenable     out  4   byte lanes
//  dbus_waitrequest    in   1   slave not ready; request must be held
//  dbus_readdata       in   32  read data
//  dbus_readdatavalid  in   1   read data returned
//  lsu_dbus_busy       out  1   stall request to the HDU
//  lsu_rdata           out  32  aligned/extended load result, valid in WB
//  lsu_load_misaligned out  1   load address misaligned (optional feature)
//  lsu_store_misaligned out 1   store address misaligned (optional feature)
// BEHAVIOUR
//  FSM states: IDLE, WAIT_RDATA. Reset -> IDLE. Reset values: lsu_rdata=0. All other outputs are combinational and are 0 in IDLE with no request.
//  IDLE: req = (mem_mem_read|mem_mem_write) & ~trap_take & ~misaligned.
//    Drive dbus_read/dbus_write combinationally from MEM inputs in the same cycle.
//  Hold rule: while dbus_waitrequest=1, request and all bus fields stay held; busy=1.
//    Pipeline stalls, so the MEM inputs stay stable.
//  Store accepted (waitrequest=0): busy=0 that cycle; stay IDLE. Write latency is zero extra cycles.
//  Load accepted: busy=1; latch mem_address[1:0] and funct3; go to WAIT_RDATA.
//  WAIT_RDATA: no bus request. busy = ~dbus_readdatavalid.
//    On readdatavalid, register the formatted data into lsu_rdata and return to IDLE.
//    Minimum load cost is one stall cycle.
//  Back-to-back: readdatavalid and the next MEM request in the following cycle are legal.
//    No request is issued in the readdatavalid cycle.
//  Store format:
//    SB: be = 4'b0001<<a[1:0], wdata = {4{b}}
//    SH: be = 4'b0011<<{a[1],1'b0}, wdata = {2{h}}
//    SW: be = 4'hF
//  Load format: select byte a[1:0] or half a[1]. LB/LH sign-extend; LBU/LHU zero-extend. LW passes through.
//  trap_take in IDLE: no request is issued; busy=0.
//  trap_take in WAIT_RDATA: the outstanding read is drained. busy stays until readdatavalid; the data is dropped and lsu_rdata is unchanged.
//  Reset during WAIT_RDATA: go to IDLE immediately. Readdatavalid after reset is ignored in IDLE.
//  Unused funct3 codes on a load behave as LW. On a store they behave as SW.
// CONFIGURATION
//  LSU_MISALIGN_CHECK_EN defined:
//    LH/LHU/SH with a[0]=1, or LW/SW with a[1:0]!=0, assert lsu_*_misaligned combinationally (gated by ~trap_take).
//    The bus access is suppressed and busy=0, so the trap is taken in WB.
//  Not defined:
//    Misaligned outputs are tied 0; the access proceeds.
//    Half uses a[1] only; word ignores a[1:0].
// TESTING
//  1. SW 0xDEADBEEF @0x100, waitrequest=0 -> be=F, data=DEADBEEF, busy=0, one cycle.
//  2. SB 0x5A @0x103, waitrequest high 3 cycles -> held be=8, wdata=5A5A5A5A; busy=1 for 3 cycles.
//  3. LB @0x102, readdata=0x00800000 after 2 cycles -> busy for 3 cycles; lsu_rdata=0xFFFFFF80.
//     LBU of the same access -> lsu_rdata=0x00000080.
//  4. LH @0x102, readdata=0x8001xxxx -> lsu_rdata=0xFFFF8001; LHU -> 0x00008001.
//  5. trap_take during WAIT_RDATA -> busy held until readdatavalid; lsu_rdata keeps its old value; IDLE next cycle.
//  6. LW @0x101: with the macro -> lsu_load_misaligned=1, dbus_read=0;
//     without the macro -> read issued at address 0x100.

Source files
------------

// File: rtl/lsu_dbus_ctrl.sv
// MEM-stage LSU data-bus controller: store lane formatting, load alignment/extension, HDU stall.
// Optional misalignment trapping is enabled by defining LSU_MISALIGN_CHECK_EN.
module lsu_dbus_ctrl #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          mem_mem_read,
    input  logic          mem_mem_write,
    input  logic [2:0]    mem_funct3,
    input  logic [AW-1:0] mem_address,
    input  logic [DW-1:0] mem_wdata,
    input  logic          trap_take,
    output logic          dbus_read,
    output logic          dbus_write,
    output logic [AW-1:0] dbus_address,
    output logic [DW-1:0] dbus_writedata,
    output logic [3:0]    dbus_byteenable,
    input  logic          dbus_waitrequest,
    input  logic [DW-1:0] dbus_readdata,
    input  logic          dbus_readdatavalid,
    output logic          lsu_dbus_busy,
    output logic [DW-1:0] lsu_rdata,
    output logic          lsu_load_misaligned,
    output logic          lsu_store_misaligned
);

    typedef enum logic [0:0] {StIdle, StWaitRdata} state_e;

    state_e        state_q, state_d;
    logic [1:0]    addr_lo_q, addr_lo_d;
    logic [2:0]    funct3_q, funct3_d;
    logic          drop_q, drop_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          is_idle;
    logic          req_rd, req_wr;
    logic [3:0]    st_be;
    logic [DW-1:0] st_data;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [DW-1:0] ld_data;

    assign is_idle = (state_q == StIdle);

`ifdef LSU_MISALIGN_CHECK_EN
    logic mis_ld, mis_st;

    always_comb begin
        unique case (mem_funct3)
            3'b000, 3'b100: mis_ld = 1'b0;
            3'b001, 3'b101: mis_ld = mem_address[0];
            default:        mis_ld = (mem_address[1:0] != 2'b00);
        endcase
        unique case (mem_funct3)
            3'b000:  mis_st = 1'b0;
            3'b001:  mis_st = mem_address[0];
            default: mis_st = (mem_address[1:0] != 2'b00);
        endcase
    end

    assign lsu_load_misaligned  = is_idle & mem_mem_read & ~trap_take & mis_ld;
    assign lsu_store_misaligned = is_idle & mem_mem_write & ~mem_mem_read & ~trap_take & mis_st;
`else
    assign lsu_load_misaligned  = 1'b0;
    assign lsu_store_misaligned = 1'b0;
`endif

    // Loads take priority should both strobes ever be asserted together.
    assign req_rd = mem_mem_read & ~trap_take & ~lsu_load_misaligned;
    assign req_wr = mem_mem_write & ~mem_mem_read & ~trap_take & ~lsu_store_misaligned;

    always_comb begin
        unique case (mem_funct3)
            3'b000: begin
                st_be   = 4'b0001 << mem_address[1:0];
                st_data = {4{mem_wdata[7:0]}};
            end
            3'b001: begin
                st_be   = 4'b0011 << {mem_address[1], 1'b0};
                st_data = {2{mem_wdata[15:0]}};
            end
            default: begin
                st_be   = 4'hF;
                st_data = mem_wdata;
            end
        endcase
    end

    assign ld_byte = dbus_readdata[{addr_lo_q, 3'b000} +: 8];
    assign ld_half = addr_lo_q[1] ? dbus_readdata[31:16] : dbus_readdata[15:0];

    always_comb begin
        unique case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'b0, ld_byte};
            3'b101:  ld_data = {16'b0, ld_half};
            default: ld_data = dbus_readdata;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        addr_lo_d     = addr_lo_q;
        funct3_d      = funct3_q;
        drop_d        = drop_q;
        rdata_d       = rdata_q;
        dbus_read     = 1'b0;
        dbus_write    = 1'b0;
        lsu_dbus_busy = 1'b0;
        unique case (state_q)
            StIdle: begin
                dbus_read     = req_rd;
                dbus_write    = req_wr;
                lsu_dbus_busy = req_rd | (req_wr & dbus_waitrequest);
                if (req_rd && !dbus_waitrequest) begin
                    state_d   = StWaitRdata;
                    addr_lo_d = mem_address[1:0];
                    funct3_d  = mem_funct3;
                    drop_d    = 1'b0;
                end
            end
            StWaitRdata: begin
                lsu_dbus_busy = ~dbus_readdatavalid;
                // A trap kills the load but the bus read must still be drained.
                if (trap_take) drop_d = 1'b1;
                if (dbus_readdatavalid) begin
                    if (!drop_q && !trap_take) rdata_d = ld_data;
                    state_d = StIdle;
                    drop_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign dbus_address    = (dbus_read | dbus_write) ? {mem_address[AW-1:2], 2'b00} : '0;
    assign dbus_writedata  = dbus_write ? st_data : '0;
    assign dbus_byteenable = dbus_write ? st_be : 4'b0000;
    assign lsu_rdata       = rdata_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= StIdle;
            addr_lo_q <= 2'b00;
            funct3_q  <= 3'b000;
            drop_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_lo_q <= addr_lo_d;
            funct3_q  <= funct3_d;
            drop_q    <= drop_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_lsu_dbus_ctrl.sv
// Directed self-checking bench for lsu_dbus_ctrl; expectations follow LSU_MISALIGN_CHECK_EN.
module tb_lsu_dbus_ctrl;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        mem_mem_read, mem_mem_write, trap_take;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_address, mem_wdata;
    logic        dbus_read, dbus_write, dbus_waitrequest, dbus_readdatavalid;
    logic [31:0] dbus_address, dbus_writedata, dbus_readdata, lsu_rdata;
    logic [3:0]  dbus_byteenable;
    logic        lsu_dbus_busy, lsu_load_misaligned, lsu_store_misaligned;

    int n_cmp = 0;
    int n_err = 0;

    lsu_dbus_ctrl #(.AW(32), .DW(32)) dut (
        .clk                 (clk),
        .rst_b               (rst_b),
        .mem_mem_read        (mem_mem_read),
        .mem_mem_write       (mem_mem_write),
        .mem_funct3          (mem_funct3),
        .mem_address         (mem_address),
        .mem_wdata           (mem_wdata),
        .trap_take           (trap_take),
        .dbus_read           (dbus_read),
        .dbus_write          (dbus_write),
        .dbus_address        (dbus_address),
        .dbus_writedata      (dbus_writedata),
        .dbus_byteenable     (dbus_byteenable),
        .dbus_waitrequest    (dbus_waitrequest),
        .dbus_readdata       (dbus_readdata),
        .dbus_readdatavalid  (dbus_readdatavalid),
        .lsu_dbus_busy       (lsu_dbus_busy),
        .lsu_rdata           (lsu_rdata),
        .lsu_load_misaligned (lsu_load_misaligned),
        .lsu_store_misaligned(lsu_store_misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_mem_read       = 1'b0;
        mem_mem_write      = 1'b0;
        mem_funct3         = 3'b000;
        mem_address        = 32'h0;
        mem_wdata          = 32'h0;
        trap_take          = 1'b0;
        dbus_waitrequest   = 1'b0;
        dbus_readdatavalid = 1'b0;
        dbus_readdata      = 32'h0;
    endtask

    // Issue a load, spend `waits` cycles in WAIT_RDATA, then return `rdata`.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input int waits, input bit trap_mid);
        mem_mem_read = 1'b1;
        mem_funct3   = f3;
        mem_address  = addr;
        @(negedge clk);
        check({tag, "_req"}, 32'(dbus_read), 32'd1);
        check({tag, "_addr"}, dbus_address, {addr[31:2], 2'b00});
        check({tag, "_busy_req"}, 32'(lsu_dbus_busy), 32'd1);
        step();
        for (int i = 0; i < waits; i++) begin
            trap_take = trap_mid && (i == 0);
            @(negedge clk);
            check({tag, "_wait_rd"}, 32'(dbus_read), 32'd0);
            check({tag, "_wait_busy"}, 32'(lsu_dbus_busy), 32'd1);
            step();
        end
        trap_take          = 1'b0;
        dbus_readdatavalid = 1'b1;
        dbus_readdata      = rdata;
        @(negedge clk);
        check({tag, "_rdv_busy"}, 32'(lsu_dbus_busy), 32'd0);
        check({tag, "_rdv_rd"}, 32'(dbus_read), 32'd0);
        step();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_b = 1'b0;
        #12;
        check("rst_rdata", lsu_rdata, 32'h0);
        check("rst_busy", 32'(lsu_dbus_busy), 32'd0);
        check("rst_rd", 32'(dbus_read), 32'd0);
        check("rst_wr", 32'(dbus_write), 32'd0);
        check("rst_be", 32'(dbus_byteenable), 32'd0);
        step();
        rst_b = 1'b1;
        step();

        // SW, accepted immediately
        mem_mem_write = 1'b1;
        mem_funct3    = 3'b010;
        mem_address   = 32'h100;
        mem_wdata     = 32'hDEADBEEF;
        @(negedge clk);
        check("sw_wr", 32'(dbus_write), 32'd1);
        check("sw_be", 32'(dbus_byteenable), 32'hF);
        check("sw_data", dbus_writedata, 32'hDEADBEEF);
        check("sw_addr", dbus_address, 32'h100);
        check("sw_busy", 32'(lsu_dbus_busy), 32'd0);
        step();
        idle_inputs();
        @(negedge clk);
        check("sw_after_wr", 32'(dbus_write), 32'd0);

        // SB held by waitrequest for three cycles
        step();
        mem_mem_write    = 1'b1;
        mem_funct3       = 3'b000;
        mem_address      = 32'h103;
        mem_wdata        = 32'h0000005A;
        dbus_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sb_hold_be", 32'(dbus_byteenable), 32'h8);
            check("sb_hold_data", dbus_writedata, 32'h5A5A5A5A);
            check("sb_hold_busy", 32'(lsu_dbus_busy), 32'd1);
            check("sb_hold_wr", 32'(dbus_write), 32'd1);
            step();
        end
        dbus_waitrequest = 1'b0;
        @(negedge clk);
        check("sb_acc_busy", 32'(lsu_dbus_busy), 32'd0);
        check("sb_acc_wr", 32'(dbus_write), 32'd1);
        step();

        // SH to upper half
        mem_mem_write = 1'b1;
        mem_funct3    = 3'b001;
        mem_address   = 32'h102;
        mem_wdata     = 32'hABCD1234;
        @(negedge clk);
        check("sh_be", 32'(dbus_byteenable), 32'hC);
        check("sh_data", dbus_writedata, 32'h12341234);
        step();
        idle_inputs();

        // Loads: sign and zero extension
        do_load("lb", 3'b000, 32'h102, 32'h00800000, 2, 1'b0);
        @(negedge clk);
        check("lb_rdata", lsu_rdata, 32'hFFFFFF80);
        check("lb_idle_busy", 32'(lsu_dbus_busy), 32'd0);
        step();
        do_load("lbu", 3'b100, 32'h102, 32'h00800000, 2, 1'b0);
        @(negedge clk);
        check("lbu_rdata", lsu_rdata, 32'h00000080);
        step();
        do_load("lh", 3'b001, 32'h102, 32'h80011234, 0, 1'b0);
        @(negedge clk);
        check("lh_rdata", lsu_rdata, 32'hFFFF8001);
        step();
        do_load("lhu", 3'b101, 32'h102, 32'h80011234, 1, 1'b0);

        // Back-to-back: store issued in the cycle right after readdatavalid
        mem_mem_write = 1'b1;
        mem_funct3    = 3'b010;
        mem_address   = 32'h200;
        mem_wdata     = 32'h11223344;
        @(negedge clk);
        check("lhu_rdata", lsu_rdata, 32'h00008001);
        check("b2b_wr", 32'(dbus_write), 32'd1);
        check("b2b_addr", dbus_address, 32'h200);
        step();
        idle_inputs();

        // Trap while waiting: read drained, data dropped
        do_load("trap", 3'b010, 32'h104, 32'h12345678, 2, 1'b1);
        @(negedge clk);
        check("trap_rdata", lsu_rdata, 32'h00008001);
        check("trap_idle_busy", 32'(lsu_dbus_busy), 32'd0);
        check("trap_idle_rd", 32'(dbus_read), 32'd0);
        step();

        // Stray readdatavalid in IDLE is ignored
        dbus_readdatavalid = 1'b1;
        dbus_readdata      = 32'hFFFFFFFF;
        step();
        idle_inputs();
        @(negedge clk);
        check("stray_rdv", lsu_rdata, 32'h00008001);
        step();

        // Trap in IDLE suppresses requests
        mem_mem_write = 1'b1;
        trap_take     = 1'b1;
        @(negedge clk);
        check("trap_idle_wr", 32'(dbus_write), 32'd0);
        check("trap_idle_wbusy", 32'(lsu_dbus_busy), 32'd0);
        step();
        mem_mem_write = 1'b0;
        mem_mem_read  = 1'b1;
        @(negedge clk);
        check("trap_idle_rreq", 32'(dbus_read), 32'd0);
        check("trap_idle_rbusy", 32'(lsu_dbus_busy), 32'd0);
        step();
        idle_inputs();

        // Reset while in WAIT_RDATA
        mem_mem_read = 1'b1;
        mem_address  = 32'h100;
        step();
        @(negedge clk);
        check("rstw_busy", 32'(lsu_dbus_busy), 32'd1);
        idle_inputs();
        #1 rst_b = 1'b0;
        #1;
        check("rstw_busy_rst", 32'(lsu_dbus_busy), 32'd0);
        check("rstw_rdata", lsu_rdata, 32'h0);
        step();
        rst_b              = 1'b1;
        dbus_readdatavalid = 1'b1;
        dbus_readdata      = 32'h000000AA;
        step();
        idle_inputs();
        @(negedge clk);
        check("rstw_rdv_ignored", lsu_rdata, 32'h0);
        step();

        // Misaligned LW
`ifdef LSU_MISALIGN_CHECK_EN
        mem_mem_read = 1'b1;
        mem_funct3   = 3'b010;
        mem_address  = 32'h101;
        @(negedge clk);
        check("mis_flag", 32'(lsu_load_misaligned), 32'd1);
        check("mis_rd", 32'(dbus_read), 32'd0);
        check("mis_busy", 32'(lsu_dbus_busy), 32'd0);
        step();
        idle_inputs();
`else
        mem_funct3  = 3'b010;
        mem_address = 32'h101;
        #1;
        check("mis_flag", 32'(lsu_load_misaligned), 32'd0);
        do_load("mislw", 3'b010, 32'h101, 32'hCAFEBABE, 1, 1'b0);
        @(negedge clk);
        check("mislw_rdata", lsu_rdata, 32'hCAFEBABE);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
